// File: rtl/dds_param_decoder.sv
// rtl/dds_param_decoder.sv - UART byte-frame decoder producing validated DDS generator parameters
`timescale 1ns/1ps
module dds_param_decoder #(
  parameter int PHASE_W     = 15,
  parameter int AMP_W       = 11,
  parameter int OFF_W       = 12,
  parameter int TYPE_W      = 2,
  parameter int AMP_MAX     = 1200,
  parameter int PHASE_RST   = 10,
  parameter int AMP_RST     = 1200,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [PHASE_W-1:0] phase,
  output logic [AMP_W-1:0]   amplitude,
  output logic [OFF_W-1:0]   offset,
  output logic [TYPE_W-1:0]  signal_type,
  output logic               new_data_flag,
  output logic               frame_err
);

  localparam int          TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] AMP_MAX16 = 16'(AMP_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_PH_H, S_PH_L, S_AMP_H, S_AMP_L, S_OFF_H, S_OFF_L, S_CHK
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             timeout;
  logic [7:0]       csum;
  logic [7:0]       sh_type;
  logic [15:0]      sh_phase, sh_amp, sh_off;
  logic             eval_pend, eval_good;
  logic             frame_ok;

  // Range checks work on the full 16-bit fields so oversized words are rejected, not truncated.
  always_comb begin
    frame_ok = (rx_data == csum) &&
               (sh_type <= 8'd2) &&
               (sh_amp <= AMP_MAX16) &&
               ((sh_phase >> PHASE_W) == 16'd0) &&
               ((sh_off >> OFF_W) == 16'd0);
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    timeout   = 1'b0;
    if (state != S_IDLE) begin
      if (rx_valid) begin
        tmr_nxt = '0;
      end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
        timeout   = 1'b1;
        tmr_nxt   = '0;
        state_nxt = S_IDLE;
      end else begin
        tmr_nxt = tmr + TMR_W'(1);
      end
    end
    if (rx_valid) begin
      case (state)
        S_IDLE:  if (rx_data == 8'hA5) state_nxt = S_TYPE;
        S_TYPE:  state_nxt = S_PH_H;
        S_PH_H:  state_nxt = S_PH_L;
        S_PH_L:  state_nxt = S_AMP_H;
        S_AMP_H: state_nxt = S_AMP_L;
        S_AMP_L: state_nxt = S_OFF_H;
        S_OFF_H: state_nxt = S_OFF_L;
        S_OFF_L: state_nxt = S_CHK;
        S_CHK:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tmr           <= '0;
      csum          <= '0;
      sh_type       <= '0;
      sh_phase      <= '0;
      sh_amp        <= '0;
      sh_off        <= '0;
      eval_pend     <= 1'b0;
      eval_good     <= 1'b0;
      phase         <= PHASE_W'(PHASE_RST);
      amplitude     <= AMP_W'(AMP_RST);
      offset        <= '0;
      signal_type   <= '0;
      new_data_flag <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmr           <= tmr_nxt;
      new_data_flag <= 1'b0;
      frame_err     <= 1'b0;
      eval_pend     <= 1'b0;

      if (timeout) begin
        frame_err <= 1'b1;
        sh_type   <= '0;
        sh_phase  <= '0;
        sh_amp    <= '0;
        sh_off    <= '0;
      end

      // Verdict is registered at the CHK byte and applied one edge later, atomically.
      if (eval_pend) begin
        if (eval_good) begin
          phase         <= sh_phase[PHASE_W-1:0];
          amplitude     <= sh_amp[AMP_W-1:0];
          offset        <= sh_off[OFF_W-1:0];
          signal_type   <= sh_type[TYPE_W-1:0];
          new_data_flag <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end

      if (rx_valid) begin
        case (state)
          S_IDLE:  if (rx_data == 8'hA5) csum <= '0;
          S_TYPE:  begin sh_type        <= rx_data; csum <= csum ^ rx_data; end
          S_PH_H:  begin sh_phase[15:8] <= rx_data; csum <= csum ^ rx_data; end
          S_PH_L:  begin sh_phase[7:0]  <= rx_data; csum <= csum ^ rx_data; end
          S_AMP_H: begin sh_amp[15:8]   <= rx_data; csum <= csum ^ rx_data; end
          S_AMP_L: begin sh_amp[7:0]    <= rx_data; csum <= csum ^ rx_data; end
          S_OFF_H: begin sh_off[15:8]   <= rx_data; csum <= csum ^ rx_data; end
          S_OFF_L: begin sh_off[7:0]    <= rx_data; csum <= csum ^ rx_data; end
          S_CHK: begin
            eval_pend <= 1'b1;
            eval_good <= frame_ok;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
